// File: rtl/fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: state encodings,
// default widths and the NOP word substituted when a fetch is aborted.
package fetch_responder_pkg;

    localparam int FETCH_STATE_WIDTH  = 2;
    localparam int DEFAULT_PC_WIDTH   = 32;
    localparam int DEFAULT_INST_WIDTH = 32;

    // addi x0, x0, 0 -- harmless filler returned by an aborted fetch
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        FETCH_STATE_IDLE = 2'd0,
        FETCH_STATE_ADDR = 2'd1,
        FETCH_STATE_DATA = 2'd2,
        FETCH_STATE_RESP = 2'd3
    } fetch_state_t;

    function automatic logic state_is_busy(input fetch_state_t s);
        return s != FETCH_STATE_IDLE;
    endfunction

endpackage

// File: rtl/fetch_responder.sv
// Single-outstanding instruction fetch: latch pc, run one address/data read on
// the instruction bus, return the word with a one-cycle inst_valid pulse.
// Optional macro FETCH_TIMEOUT_EN aborts a stalled fetch after TIMEOUT_CYCLES.
module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter int PC_WIDTH       = DEFAULT_PC_WIDTH,
    parameter int INST_WIDTH     = DEFAULT_INST_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_fetch,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  fetch_error,
    output logic                  busy,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [PC_WIDTH-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [INST_WIDTH-1:0] ir_data
);

    fetch_state_t          state_reg;
    logic [PC_WIDTH-1:0]   addr_reg;
    logic [INST_WIDTH-1:0] inst_reg;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             abort_reg;
    logic             timeout_hit;

    assign timeout_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_error = abort_reg && (state_reg == FETCH_STATE_RESP);
`else
    assign fetch_error = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    // Every output is a pure decode of registered state: no input reaches an output.
    assign inst_valid    = (state_reg == FETCH_STATE_RESP);
    assign ir_addr_valid = (state_reg == FETCH_STATE_ADDR);
    assign ir_data_ready = (state_reg == FETCH_STATE_DATA);
    assign busy          = state_is_busy(state_reg);
    assign ir_addr       = addr_reg;
    assign inst          = inst_reg;

    logic unused_pc_low;
    assign unused_pc_low = ^pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= FETCH_STATE_IDLE;
            addr_reg  <= '0;
            inst_reg  <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_reg <= '0;
            abort_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                FETCH_STATE_IDLE: begin
                    if (inst_fetch) begin
                        addr_reg  <= {pc[PC_WIDTH-1:2], 2'b00};
                        state_reg <= FETCH_STATE_ADDR;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // IDLE always precedes ADDR, so clearing here is clearing on entry.
                    tmo_cnt_reg <= '0;
                    abort_reg   <= 1'b0;
`endif
                end

                FETCH_STATE_ADDR: begin
                    if (ir_addr_ready) begin
                        state_reg <= FETCH_STATE_DATA;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_reg <= FETCH_STATE_RESP;
                        inst_reg  <= INST_WIDTH'(INST_NOP);
                        abort_reg <= 1'b1;
                    end
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
`endif
                end

                FETCH_STATE_DATA: begin
                    // A beat arriving on the expiry cycle still completes normally.
                    if (ir_data_valid) begin
                        inst_reg  <= ir_data;
                        state_reg <= FETCH_STATE_RESP;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_reg <= FETCH_STATE_RESP;
                        inst_reg  <= INST_WIDTH'(INST_NOP);
                        abort_reg <= 1'b1;
                    end
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
`endif
                end

                FETCH_STATE_RESP: begin
                    state_reg <= FETCH_STATE_IDLE;
                end

                default: begin
                    state_reg <= FETCH_STATE_IDLE;
                end
            endcase
        end
    end

endmodule
